// File: rtl/vector_capture.sv
// vector_capture: assembles four serial lane samples into a vector, retires the
// previous vector, launches the downstream diff stage and waits for its done
// (or a timeout) while holding both vectors stable.
module vector_capture #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_valid,
  input  logic [WIDTH-1:0]     sample_data,
  output logic                 sample_ready,
  input  logic                 flush,
  output logic [4*WIDTH-1:0]   vec_new,
  output logic [4*WIDTH-1:0]   vec_old,
  output logic                 start,
  input  logic                 done,
  output logic                 busy,
  output logic                 primed,
  output logic                 timeout_err,
  output logic [7:0]           frame_count
);

  // Counter must be able to hold TIMEOUT itself.
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StLaunch,
    StWait
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           lane_idx_q, lane_idx_d;
  // Only lanes 0..2 are buffered; the 4th sample goes straight into the vector.
  logic [3*WIDTH-1:0]   buf_q, buf_d;
  logic [4*WIDTH-1:0]   vec_new_q, vec_new_d;
  logic [4*WIDTH-1:0]   vec_old_q, vec_old_d;
  logic                 primed_q, primed_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [7:0]           frame_count_q, frame_count_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  logic                 accept;
  logic [4*WIDTH-1:0]   assembled;

  // Flow control and outputs decoded from registered state.
  always_comb begin
    sample_ready = (state_q == StFill) && !flush;
    start        = (state_q == StLaunch);
    busy         = (state_q == StLaunch) || (state_q == StWait);
    accept       = sample_valid && sample_ready;
    assembled    = {sample_data, buf_q};
  end

  // Next-state logic for the capture / handshake sequence.
  always_comb begin
    state_d       = state_q;
    lane_idx_d    = lane_idx_q;
    buf_d         = buf_q;
    vec_new_d     = vec_new_q;
    vec_old_d     = vec_old_q;
    primed_d      = primed_q;
    timeout_err_d = timeout_err_q;
    frame_count_d = frame_count_q;
    cnt_d         = cnt_q;

    unique case (state_q)
      StIdle: begin
        state_d = StFill;
      end

      StFill: begin
        if (flush) begin
          lane_idx_d = 2'd0;
          primed_d   = 1'b0;
        end else if (accept) begin
          if (lane_idx_q == 2'd3) begin
            lane_idx_d = 2'd0;
            vec_new_d  = assembled;
            if (primed_q) begin
              vec_old_d = vec_new_q;
              state_d   = StLaunch;
            end else begin
              // First vector after reset/flush only primes; nothing to diff yet.
              primed_d = 1'b1;
            end
          end else begin
            for (int unsigned i = 0; i < 3; i++) begin
              if (lane_idx_q == 2'(i)) begin
                buf_d[i*WIDTH +: WIDTH] = sample_data;
              end
            end
            lane_idx_d = lane_idx_q + 2'd1;
          end
        end
      end

      StLaunch: begin
        cnt_d   = '0;
        state_d = StWait;
      end

      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        // done has priority over an expiring timeout.
        if (done) begin
          frame_count_d = frame_count_q + 8'd1;
          timeout_err_d = 1'b0;
          state_d       = StFill;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = StFill;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      lane_idx_q    <= 2'd0;
      buf_q         <= '0;
      vec_new_q     <= '0;
      vec_old_q     <= '0;
      primed_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      frame_count_q <= 8'd0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      lane_idx_q    <= lane_idx_d;
      buf_q         <= buf_d;
      vec_new_q     <= vec_new_d;
      vec_old_q     <= vec_old_d;
      primed_q      <= primed_d;
      timeout_err_q <= timeout_err_d;
      frame_count_q <= frame_count_d;
      cnt_q         <= cnt_d;
    end
  end

  assign vec_new     = vec_new_q;
  assign vec_old     = vec_old_q;
  assign primed      = primed_q;
  assign timeout_err = timeout_err_q;
  assign frame_count = frame_count_q;

`ifndef SYNTHESIS
  // The diff stage relies on both vectors holding still for the whole handshake.
  a_vec_stable : assert property (@(posedge clk) disable iff (!reset)
    busy |=> ($stable(vec_new_q) && $stable(vec_old_q)));

  a_no_ready_when_busy : assert property (@(posedge clk) disable iff (!reset)
    busy |-> !sample_ready);
`endif

endmodule

// File: tb/tb_vector_capture.sv
// Self-checking bench for vector_capture: an event-level model predicts every
// output each cycle; directed literal checks pin the model to hand values.
module tb_vector_capture;

  localparam int W  = 4;
  localparam int TO = 15;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             sample_valid = 1'b0;
  logic [W-1:0]     sample_data = '0;
  logic             flush = 1'b0;
  logic             done = 1'b0;
  logic             sample_ready;
  logic [4*W-1:0]   vec_new;
  logic [4*W-1:0]   vec_old;
  logic             start;
  logic             busy;
  logic             primed;
  logic             timeout_err;
  logic [7:0]       frame_count;

  vector_capture #(
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ready (sample_ready),
    .flush        (flush),
    .vec_new      (vec_new),
    .vec_old      (vec_old),
    .start        (start),
    .done         (done),
    .busy         (busy),
    .primed       (primed),
    .timeout_err  (timeout_err),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- behavioural model ----------------
  // m_age: -1 = not in a handshake, 0 = launch cycle, k>=1 = k-th cycle awaiting done.
  bit             m_after_reset = 1'b1;
  int             m_age = -1;
  bit             m_primed = 1'b0;
  bit             m_terr = 1'b0;
  logic [7:0]     m_fc = 8'd0;
  logic [4*W-1:0] m_vnew = '0;
  logic [4*W-1:0] m_vold = '0;
  logic [W-1:0]   m_q[$];

  function automatic logic [4*W-1:0] pack4(input logic [W-1:0] a0, input logic [W-1:0] a1,
                                           input logic [W-1:0] a2, input logic [W-1:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_after_reset = 1'b1;
      m_age         = -1;
      m_primed      = 1'b0;
      m_terr        = 1'b0;
      m_fc          = 8'd0;
      m_vnew        = '0;
      m_vold        = '0;
      m_q.delete();
    end else if (m_after_reset) begin
      m_after_reset = 1'b0;
    end else if (m_age < 0) begin
      if (flush) begin
        m_q.delete();
        m_primed = 1'b0;
      end else if (sample_valid) begin
        m_q.push_back(sample_data);
        if (m_q.size() == 4) begin
          if (m_primed) begin
            m_vold = m_vnew;
            m_age  = 0;
          end
          m_vnew   = pack4(m_q[0], m_q[1], m_q[2], m_q[3]);
          m_primed = 1'b1;
          m_q.delete();
        end
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else begin
      if (done) begin
        m_fc   = m_fc + 8'd1;
        m_terr = 1'b0;
        m_age  = -1;
      end else if (m_age == TO) begin
        m_terr = 1'b1;
        m_age  = -1;
      end else begin
        m_age = m_age + 1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [6+8+8*W-1:0] act;
    logic [6+8+8*W-1:0] exp;
    logic e_ready;
    e_ready = reset && !m_after_reset && (m_age < 0) && !flush;
    act = {sample_ready, start, busy, primed, timeout_err, 1'b0, frame_count, vec_new, vec_old};
    exp = {e_ready, m_age == 0, m_age >= 0, m_primed, m_terr, 1'b0, m_fc, m_vnew, m_vold};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL cycle_outputs t=%0t: got rdy=%b st=%b bsy=%b pr=%b to=%b fc=%0d new=%h old=%h, expected rdy=%b st=%b bsy=%b pr=%b to=%b fc=%0d new=%h old=%h",
               $time, sample_ready, start, busy, primed, timeout_err, frame_count, vec_new,
               vec_old, e_ready, m_age == 0, m_age >= 0, m_primed, m_terr, m_fc, m_vnew, m_vold);
    end
  end

  // Pulse / occupancy counters, only ever read as differences.
  int n_start = 0;
  int n_busy  = 0;
  always @(negedge clk) begin
    if (start) n_start++;
    if (busy)  n_busy++;
  end

  // Diff-stage stand-in. Mode 0: done 5 cycles after start, dropped the cycle after
  // start. Mode 1: done stuck high. Mode 2: done stuck low.
  int dmode = 0;
  initial begin
    int  since;
    bit  st;
    since = -1;
    forever begin
      @(negedge clk);
      st = start;
      @(posedge clk);
      #1;
      if (st) since = 0;
      else if (since >= 0 && since < 1000) since++;
      case (dmode)
        1:       done = 1'b1;
        2:       done = 1'b0;
        default: done = (since >= 4);
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one sample and hold it until accepted (bounded).
  task automatic send(input logic [W-1:0] d);
    bit acc;
    acc = 1'b0;
    sample_valid = 1'b1;
    sample_data  = d;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = sample_ready;
      @(posedge clk);
      #1;
    end
    sample_valid = 1'b0;
    check("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic send4(input logic [W-1:0] a0, input logic [W-1:0] a1,
                       input logic [W-1:0] a2, input logic [W-1:0] a3);
    send(a0);
    send(a1);
    send(a2);
    send(a3);
  endtask

  initial begin
    int s0;
    int b0;

    #1 reset = 1'b0;
    #11;
    check("reset_ready", 32'(sample_ready), 32'd0);
    check("reset_vec_new", 32'(vec_new), 32'h0);
    check("reset_frame_count", 32'(frame_count), 32'd0);
    #10 reset = 1'b1;
    @(posedge clk);
    #1;

    // Prime with 1,2,3,4: no launch.
    s0 = n_start;
    send4(4'h1, 4'h2, 4'h3, 4'h4);
    check("prime_vec_new", 32'(vec_new), 32'h4321);
    check("prime_primed", 32'(primed), 32'd1);
    wait_cycles(3);
    check("prime_no_start", 32'(n_start - s0), 32'd0);

    // First real launch with 5-cycle done latency.
    b0 = n_busy;
    send4(4'h5, 4'h6, 4'h7, 4'h8);
    wait_cycles(10);
    check("l1_vec_old", 32'(vec_old), 32'h4321);
    check("l1_vec_new", 32'(vec_new), 32'h8765);
    check("l1_start_count", 32'(n_start - s0), 32'd1);
    check("l1_busy_cycles", 32'(n_busy - b0), 32'd6);
    check("l1_frame_count", 32'(frame_count), 32'd1);

    // done already high: completes on the first wait cycle.
    dmode = 1;
    b0 = n_busy;
    send4(4'h9, 4'hA, 4'hB, 4'hC);
    wait_cycles(8);
    check("hot_busy_cycles", 32'(n_busy - b0), 32'd2);
    check("hot_frame_count", 32'(frame_count), 32'd2);
    check("hot_vec_new", 32'(vec_new), 32'hCBA9);

    // done never arrives: timeout after 15 wait cycles.
    dmode = 2;
    b0 = n_busy;
    send4(4'h1, 4'h1, 4'h1, 4'h1);
    wait_cycles(22);
    check("to_busy_cycles", 32'(n_busy - b0), 32'd16);
    check("to_err", 32'(timeout_err), 32'd1);
    check("to_frame_count", 32'(frame_count), 32'd2);

    // Next successful launch clears the sticky error.
    dmode = 0;
    send4(4'h2, 4'h2, 4'h2, 4'h2);
    wait_cycles(10);
    check("rec_err", 32'(timeout_err), 32'd0);
    check("rec_frame_count", 32'(frame_count), 32'd3);

    // Flush after two samples, with a sample offered in the flush cycle.
    s0 = n_start;
    send(4'h5);
    send(4'h6);
    flush = 1'b1;
    sample_valid = 1'b1;
    sample_data = 4'hF;
    @(negedge clk);
    #1;
    check("flush_ready", 32'(sample_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    sample_valid = 1'b0;
    check("flush_primed", 32'(primed), 32'd0);
    check("flush_vec_new_kept", 32'(vec_new), 32'h2222);
    send4(4'hA, 4'hB, 4'hC, 4'hD);
    wait_cycles(3);
    check("flush_vec_new", 32'(vec_new), 32'hDCBA);
    check("flush_vec_old", 32'(vec_old), 32'h1111);
    check("flush_no_start", 32'(n_start - s0), 32'd0);

    // Back-to-back launches with valid held through each handshake; 3+253 wraps to 0.
    for (int i = 0; i < 253; i++) begin
      send4(4'(i), 4'(i + 1), 4'(i + 2), 4'(i + 3));
    end
    wait_cycles(10);
    check("wrap_frame_count", 32'(frame_count), 32'd0);
    check("wrap_vec_new", 32'(vec_new), 32'hFEDC);

    // Reset in the middle of a wait.
    dmode = 2;
    send4(4'h3, 4'h3, 4'h3, 4'h3);
    wait_cycles(3);
    check("mid_busy_before", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_start", 32'(start), 32'd0);
    check("mid_primed", 32'(primed), 32'd0);
    check("mid_vec_new", 32'(vec_new), 32'h0);
    check("mid_vec_old", 32'(vec_old), 32'h0);
    check("mid_frame_count", 32'(frame_count), 32'd0);
    check("mid_ready", 32'(sample_ready), 32'd0);
    #10 reset = 1'b1;
    dmode = 0;
    @(posedge clk);
    #1;
    s0 = n_start;
    send4(4'h1, 4'h2, 4'h3, 4'h4);
    wait_cycles(4);
    check("restart_primed", 32'(primed), 32'd1);
    check("restart_vec_new", 32'(vec_new), 32'h4321);
    check("restart_no_start", 32'(n_start - s0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vector_capture.md
# vector_capture

Upstream feeder for the `vector_diff` stage. It accepts a serial stream of WIDTH-bit lane samples and assembles each group of four into a vector. On each completed vector it retires the previous vector to `vec_old`, presents both vectors, and pulses `start`. It then holds both vectors stable until the diff stage signals `done`, or until a timeout expires.

## Interface
- `WIDTH`, default 4: bits per lane; vectors are 4*WIDTH bits.
- `TIMEOUT`, default 15: maximum WAIT cycles before the handshake is abandoned; must be at least 6.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset: 0 resets the block; release is taken on a clk edge.
- `sample_valid`  in  1  `sample_data` is valid this cycle.
- `sample_data`  in  WIDTH  lane sample.
- `sample_ready`  out  1  sample is accepted when `sample_valid && sample_ready`.
- `flush`  in  1  discard any partial vector and de-prime.
- `vec_new`  out  4*WIDTH  newest complete vector; lane 0 at bits [WIDTH-1:0].
- `vec_old`  out  4*WIDTH  previous complete vector.
- `start`  out  1  one-cycle pulse that launches the diff stage.
- `done`  in  1  completion level from the diff stage.
- `busy`  out  1  high in LAUNCH or WAIT.
- `primed`  out  1  `vec_new` holds a valid vector.
- `timeout_err`  out  1  sticky flag: the last launch got no `done`.
- `frame_count`  out  8  count of completed diff handshakes; wraps 255 -> 0.

## Operation
- States: IDLE, FILL, LAUNCH, WAIT.
- **IDLE:** entered only by reset; unconditionally moves to FILL on the next cycle.
- **FILL:**
  - `sample_ready = !flush`.
  - Each accepted sample is written to assembly-buffer lane `lane_idx` (0..3), then `lane_idx` increments.
  - The first sample goes to lane 0.
- **4th accepted sample (`lane_idx==3`):**
  - If `primed==0`: load buffer plus this sample into `vec_new`, set `primed`, clear `lane_idx`, stay in FILL. No `start` is issued.
  - If `primed==1`: `vec_old <= vec_new`, `vec_new <= assembled`, clear `lane_idx`, go to LAUNCH.
- **LAUNCH:** `start=1` for exactly this one cycle; go to WAIT; clear the timeout counter.
- **WAIT:**
  - Each cycle, the timeout counter increments.
  - If `done==1`: `frame_count++`, clear `timeout_err`, go to FILL.
  - Else if the counter reaches TIMEOUT: set `timeout_err`, go to FILL. `frame_count` is unchanged.
- **`flush`:**
  - In FILL: clears `lane_idx` and `primed`. Any sample presented that cycle is not accepted, because `sample_ready` is low.
  - In LAUNCH/WAIT: ignored.
  - `vec_new` and `vec_old` keep their values.
- `vec_new` and `vec_old` change only on the 4th-sample edge. They are constant from LAUNCH through the exit from WAIT.
- `start` is never asserted outside LAUNCH.

## Timing
- Reset values:
  - state IDLE, `lane_idx`=0.
  - `vec_new`, `vec_old`, assembly buffer all 0.
  - `start`, `busy`, `primed`, `timeout_err` = 0; `frame_count`=0.
  - `sample_ready`=0.
- `sample_ready` is combinational from state and `flush`. It is 0 during reset and IDLE.
- `start` and `busy` are decoded from registered state.
- Latency:
  - 4th accept at cycle c → vectors updated and `start`=1 at c+1; WAIT from c+2.
  - `done` is sampled only in WAIT. The stale `done` level left high from the previous job is therefore never seen: the diff stage drops `done` the cycle after `start`.
  - With the diff stage's 5-cycle start→`done` latency, `done` arrives at c+6 and FILL resumes at c+7.
- `done` arriving in the same cycle the counter reaches TIMEOUT: `done` wins (success path).
- Reset asserted mid-WAIT: all state clears immediately, with no further `start`.

## Test plan
- Reset, then 4 samples 1,2,3,4 → `primed`=1, `vec_new`=16'h4321, no `start` pulse, `sample_ready` stays high.
- Continue with samples 5,6,7,8, then `done` 5 cycles after `start` → `vec_old`=16'h4321, `vec_new`=16'h8765, exactly one `start` cycle, `busy` high LAUNCH..WAIT, `frame_count`=1, vectors stable throughout WAIT.
- Primed block, launch with `done` held high before `start` and through WAIT → completes on the first WAIT cycle; `done` low for the whole launch → `timeout_err`=1 after 15 WAIT cycles, `frame_count` unchanged, next successful launch clears `timeout_err`.
- `flush` after 2 samples, then samples A,B,C,D → partial data discarded, `primed` was cleared, `vec_new`=16'hDCBA, no `start`; `flush` together with `sample_valid` → sample not accepted.
- `sample_valid` held high during LAUNCH/WAIT → `sample_ready`=0, no samples lost or accepted; 256 launches → `frame_count` wraps to 0.
- Reset pulsed low mid-WAIT → all outputs return to reset values asynchronously; the block restarts unprimed.
